// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execution unit: 3-bit control codes and FSM states.
package alu_pkg;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_ADD  = 3'b010;
    localparam logic [2:0] ALU_PASS = 3'b011;
    localparam logic [2:0] ALU_RSVD = 3'b100;
    localparam logic [2:0] ALU_SRLV = 3'b101;
    localparam logic [2:0] ALU_SUB  = 3'b110;
    localparam logic [2:0] ALU_SLT  = 3'b111;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

endpackage

// File: rtl/alu_exec_unit_if.sv
// Request/response bundle between the register-read stage, the ALU unit and writeback.
interface alu_exec_unit_if #(
    parameter int WIDTH = 32
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       gctl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic             zero;
    logic             ovf;
    logic             illegal;

    modport master (
        output in_valid, gctl, a, b, out_ready,
        input  in_ready, out_valid, result, zero, ovf, illegal
    );

    modport slave (
        input  in_valid, gctl, a, b, out_ready,
        output in_ready, out_valid, result, zero, ovf, illegal
    );
endinterface

// File: rtl/alu_comb_core.sv
// Single-cycle ALU operations; shift and reserved codes yield zero here and are handled above.
module alu_comb_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    input  logic [2:0]       i_gctl,
    output logic [WIDTH-1:0] o_result,
    output logic             o_ovf
);
    logic             w_is_sub;
    logic [WIDTH-1:0] w_b_eff;
    logic [WIDTH-1:0] w_sum;
    logic             w_sum_ovf;

    // Subtraction shares the adder: a + ~b + 1.
    assign w_is_sub  = (i_gctl == ALU_SUB);
    assign w_b_eff   = w_is_sub ? ~i_b : i_b;
    assign w_sum     = i_a + w_b_eff + {{(WIDTH-1){1'b0}}, w_is_sub};
    assign w_sum_ovf = (i_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != i_a[WIDTH-1]);

    always_comb begin
        // NOTE: defaults first so codes not listed below never infer a latch.
        o_result = '0;
        o_ovf    = 1'b0;
        case (i_gctl)
            ALU_AND:  o_result = i_a & i_b;
            ALU_OR:   o_result = i_a | i_b;
            ALU_ADD,
            ALU_SUB: begin
                o_result = w_sum;
                o_ovf    = w_sum_ovf;
            end
            ALU_SLT:  o_result = {{(WIDTH-1){1'b0}}, ($signed(i_a) < $signed(i_b))};
            ALU_PASS: o_result = i_a;
            default:  o_result = '0;
        endcase
    end
endmodule

// File: rtl/alu_exec_unit.sv
// ALU execution unit: accepts a decoded op, runs single-cycle ops or an iterative
// logical right shift, and holds a registered result until writeback takes it.
module alu_exec_unit
    import alu_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    alu_exec_unit_if.slave  bus
);
    state_t             r_state;
    logic [WIDTH-1:0]   r_work;
    logic [SHAMT_W-1:0] r_cnt;
    logic [WIDTH-1:0]   r_result;
    logic               r_zero;
    logic               r_ovf;
    logic               r_illegal;
    logic               r_out_valid;
    logic               r_in_ready;

    logic [WIDTH-1:0]   w_core_result;
    logic               w_core_ovf;
    logic [SHAMT_W-1:0] w_shamt;
    logic [WIDTH-1:0]   w_work_next;

    alu_comb_core #(.WIDTH(WIDTH)) u_core (
        .i_a      (bus.a),
        .i_b      (bus.b),
        .i_gctl   (bus.gctl),
        .o_result (w_core_result),
        .o_ovf    (w_core_ovf)
    );

    assign w_shamt     = bus.a[SHAMT_W-1:0];
    assign w_work_next = r_work >> 1;

    // NOTE: sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_work      <= '0;
            r_cnt       <= '0;
            r_result    <= '0;
            r_zero      <= 1'b0;
            r_ovf       <= 1'b0;
            r_illegal   <= 1'b0;
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_in_ready <= 1'b1;
                    if (r_in_ready && bus.in_valid) begin
                        r_in_ready <= 1'b0;
                        if (bus.gctl == ALU_SRLV) begin
                            r_work    <= bus.b;
                            r_cnt     <= w_shamt;
                            r_ovf     <= 1'b0;
                            r_illegal <= 1'b0;
                            if (w_shamt == '0) begin
                                r_result    <= bus.b;
                                r_zero      <= (bus.b == '0);
                                r_out_valid <= 1'b1;
                                r_state     <= S_DONE;
                            end else begin
                                r_state <= S_SHIFT;
                            end
                        end else begin
                            r_result    <= w_core_result;
                            r_zero      <= (w_core_result == '0);
                            r_ovf       <= w_core_ovf;
                            r_illegal   <= (bus.gctl == ALU_RSVD);
                            r_out_valid <= 1'b1;
                            r_state     <= S_DONE;
                        end
                    end
                end
                S_SHIFT: begin
                    r_work <= w_work_next;
                    r_cnt  <= r_cnt - 1'b1;
                    if (r_cnt == SHAMT_W'(1)) begin
                        r_result    <= w_work_next;
                        r_zero      <= (w_work_next == '0);
                        r_out_valid <= 1'b1;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    // Result and flags stay frozen until writeback takes them.
                    if (bus.out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready  = r_in_ready;
    assign bus.out_valid = r_out_valid;
    assign bus.result    = r_result;
    assign bus.zero      = r_zero;
    assign bus.ovf       = r_ovf;
    assign bus.illegal   = r_illegal;
endmodule

// File: tb/tb_alu_exec_unit.sv
// Scoreboard bench for alu_exec_unit: directed corner cases plus randomized ops with
// random writeback backpressure, checked against an arithmetic reference model.
module tb_alu_exec_unit;
    import alu_pkg::*;

    localparam int WIDTH = 32;
    localparam longint MAXS = 64'sh7FFF_FFFF;
    localparam longint MINS = -MAXS - 1;

    typedef struct {
        logic [31:0] result;
        logic        zero;
        logic        ovf;
        logic        illegal;
        int          lat;
        int          acc;
    } exp_t;

    logic clk;
    logic rst_n;
    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   bp_mode  = 0;
    int   n_done   = 0;
    bit   seen     = 0;

    alu_exec_unit_if #(.WIDTH(WIDTH)) bus ();

    alu_exec_unit #(.WIDTH(WIDTH), .SHAMT_W(5)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Writeback readiness: 0 always ready, 1 random, 2 stalled.
    always @(posedge clk) begin
        #1;
        case (bp_mode)
            0:       bus.out_ready = 1'b1;
            2:       bus.out_ready = 1'b0;
            default: bus.out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic exp_t model(input logic [2:0] g, input logic [31:0] a, input logic [31:0] b);
        exp_t   e;
        longint sa, sb_v, s;
        sa   = longint'($signed(a));
        sb_v = longint'($signed(b));
        e.result  = '0;
        e.ovf     = 1'b0;
        e.illegal = 1'b0;
        e.lat     = 1;
        e.acc     = 0;
        case (g)
            ALU_AND:  e.result = a & b;
            ALU_OR:   e.result = a | b;
            ALU_ADD: begin
                s = sa + sb_v;
                e.result = 32'(s);
                e.ovf    = (s > MAXS) || (s < MINS);
            end
            ALU_SUB: begin
                s = sa - sb_v;
                e.result = 32'(s);
                e.ovf    = (s > MAXS) || (s < MINS);
            end
            ALU_SLT:  e.result = (sa < sb_v) ? 32'd1 : 32'd0;
            ALU_PASS: e.result = a;
            ALU_SRLV: begin
                e.result = b >> a[4:0];
                e.lat    = int'(a[4:0]) + 1;
            end
            default: begin
                e.result  = '0;
                e.illegal = 1'b1;
            end
        endcase
        e.zero = (e.result == 32'd0);
        return e;
    endfunction

    function automatic logic [31:0] pick();
        logic [31:0] edges [5];
        edges = '{32'h0, 32'h1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return edges[$urandom_range(0, 4)];
        return $urandom();
    endfunction

    task automatic issue(input logic [2:0] g, input logic [31:0] av, input logic [31:0] bv);
        exp_t e;
        int   n;
        @(posedge clk);
        #1;
        bus.gctl     = g;
        bus.a        = av;
        bus.b        = bv;
        bus.in_valid = 1'b1;
        n = 0;
        @(negedge clk);
        while (bus.in_ready !== 1'b1 && n < 300) begin
            n++;
            @(negedge clk);
        end
        if (bus.in_ready !== 1'b1) begin
            check("accept_timeout", {63'd0, bus.in_ready}, 64'd1);
        end else begin
            e     = model(g, av, bv);
            e.acc = cyc + 1;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("drain", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: checks latency on the first valid cycle and the payload on every valid cycle.
    always @(negedge clk) begin
        if (!rst_n) begin
            seen = 1'b0;
        end else if (sb.size() == 0) begin
            check("idle_out_valid", {63'd0, bus.out_valid}, 64'd0);
        end else if (bus.out_valid === 1'b1) begin
            if (!seen) begin
                check($sformatf("latency[%0d]", n_done), 64'(cyc - sb[0].acc + 1), 64'(sb[0].lat));
                seen = 1'b1;
            end
            check($sformatf("result[%0d]", n_done), {32'd0, bus.result}, {32'd0, sb[0].result});
            check($sformatf("zero[%0d]", n_done), {63'd0, bus.zero}, {63'd0, sb[0].zero});
            check($sformatf("ovf[%0d]", n_done), {63'd0, bus.ovf}, {63'd0, sb[0].ovf});
            check($sformatf("illegal[%0d]", n_done), {63'd0, bus.illegal}, {63'd0, sb[0].illegal});
            check($sformatf("in_ready_busy[%0d]", n_done), {63'd0, bus.in_ready}, 64'd0);
            if (bus.out_ready === 1'b1) begin
                void'(sb.pop_front());
                seen = 1'b0;
                n_done++;
            end
        end
    end

    initial begin
        int          n;
        logic [2:0]  g;
        logic [31:0] av;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b1;
        bus.gctl      = ALU_ADD;
        bus.a         = 32'd1;
        bus.b         = 32'd2;
        bus.out_ready = 1'b1;

        repeat (3) @(negedge clk);
        check("rst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("rst_result", {32'd0, bus.result}, 64'd0);
        @(posedge clk);
        #1;
        rst_n        = 1'b1;
        bus.in_valid = 1'b0;
        repeat (2) @(negedge clk);
        check("release_in_ready", {63'd0, bus.in_ready}, 64'd1);

        issue(ALU_ADD,  32'h7FFF_FFFF, 32'h1);
        issue(ALU_SUB,  32'd5, 32'd5);
        issue(ALU_SLT,  32'hFFFF_FFFE, 32'd3);
        issue(ALU_SLT,  32'd3, 32'hFFFF_FFFE);
        issue(ALU_SRLV, 32'd4, 32'hF000_0000);
        issue(ALU_SRLV, 32'd0, 32'hDEAD_BEEF);
        issue(ALU_SRLV, 32'h3F, 32'h8000_0000);
        issue(ALU_PASS, 32'h1234_5678, 32'hFFFF_FFFF);
        issue(ALU_RSVD, 32'hCAFE_F00D, 32'h1357_9BDF);
        issue(ALU_AND,  32'hF0F0_F0F0, 32'hFF00_FF00);
        issue(ALU_OR,   32'hF0F0_F0F0, 32'h0F0F_0000);
        issue(ALU_SUB,  32'h8000_0000, 32'h1);
        drain();

        // Stall writeback for several cycles while a new request is pending.
        bp_mode = 2;
        issue(ALU_SUB, 32'h10, 32'h3);
        n = 0;
        while (bus.out_valid !== 1'b1 && n < 50) begin
            n++;
            @(negedge clk);
        end
        @(posedge clk);
        #1;
        bus.gctl     = ALU_OR;
        bus.a        = 32'hA5A5_0000;
        bus.b        = 32'h0000_5A5A;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("bp_result", {32'd0, bus.result}, 64'hD);
            check("bp_zero", {63'd0, bus.zero}, 64'd0);
            check("bp_out_valid", {63'd0, bus.out_valid}, 64'd1);
            check("bp_in_ready", {63'd0, bus.in_ready}, 64'd0);
        end
        bus.in_valid = 1'b0;
        bp_mode      = 0;
        repeat (2) @(negedge clk);
        check("bp_release_in_ready", {63'd0, bus.in_ready}, 64'd1);
        check("bp_release_out_valid", {63'd0, bus.out_valid}, 64'd0);
        issue(ALU_OR, 32'hA5A5_0000, 32'h0000_5A5A);
        drain();

        // Reset in the middle of a long shift abandons it.
        issue(ALU_SRLV, 32'd20, 32'hFFFF_0000);
        repeat (6) @(posedge clk);
        #1;
        rst_n = 1'b0;
        sb.delete();
        repeat (2) @(negedge clk);
        check("midrst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        check("midrst_in_ready", {63'd0, bus.in_ready}, 64'd0);
        check("midrst_result", {32'd0, bus.result}, 64'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (25) @(negedge clk);
        check("midrst_idle_in_ready", {63'd0, bus.in_ready}, 64'd1);
        issue(ALU_ADD, 32'h8000_0000, 32'h8000_0000);
        drain();

        // Random ops with random writeback stalls.
        bp_mode = 1;
        for (int i = 0; i < 80; i++) begin
            g  = 3'($urandom_range(0, 7));
            av = pick();
            issue(g, av, pick());
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(posedge clk);
        end
        drain();
        bp_mode = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
